// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter and its bench.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_ROT = 2'd0,
    MODE_LSH = 2'd1,
    MODE_ASH = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One registered right-shifting stage; applies DIST when the top remaining amt bit is set.
module shifter_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIST  = 1,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [AW-1:0]    i_amt,
  input  logic             i_dir,
  input  mode_e            i_mode,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AW-1:0]    o_amt,
  output logic             o_dir,
  output mode_e            o_mode
);

  logic             w_fill;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_shf;
  logic [WIDTH-1:0] w_next;

  // Left ops arrive bit-reversed, so only a right arithmetic shift replicates the MSB.
  always_comb begin
    w_fill = ((i_mode == MODE_ASH) && (i_dir == DIR_RIGHT)) ? i_data[WIDTH-1] : 1'b0;
    w_rot  = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
    w_shf  = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};
    w_next = i_data;
    if (i_amt[AW-1]) begin
      case (i_mode)
        MODE_LSH, MODE_ASH: w_next = w_shf;
        default:            w_next = w_rot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_amt   <= '0;
      o_dir   <= 1'b0;
      o_mode  <= MODE_ROT;
    end else if (i_adv) begin
      o_valid <= i_valid;
      o_data  <= w_next;
      o_amt   <= i_amt << 1;
      o_dir   <= i_dir;
      o_mode  <= i_mode;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// AW-stage rotate/shift pipeline with whole-pipe stall; left ops reuse the right datapath via bit reversal.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("WIDTH must be a power of two in 4..64");
  end

  function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return r;
  endfunction

  logic             w_adv;
  logic             w_valid [0:AW];
  logic [WIDTH-1:0] w_data  [0:AW];
  logic [AW-1:0]    w_amt   [0:AW];
  logic             w_dir   [0:AW];
  mode_e            w_mode  [0:AW];
  logic             w_unused;

  assign w_adv    = !w_valid[AW] || out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = (in_dir == DIR_LEFT) ? f_rev(in_data) : in_data;
  assign w_amt[0]   = in_amt;
  assign w_dir[0]   = in_dir;
  assign w_mode[0]  = mode_e'(in_mode);

  for (genvar k = 0; k < AW; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (AW - 1 - k))
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .i_adv   (w_adv),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_amt   (w_amt[k]),
      .i_dir   (w_dir[k]),
      .i_mode  (w_mode[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_amt   (w_amt[k+1]),
      .o_dir   (w_dir[k+1]),
      .o_mode  (w_mode[k+1])
    );
  end

  assign out_valid = w_valid[AW];
  assign out_data  = (w_dir[AW] == DIR_LEFT) ? f_rev(w_data[AW]) : w_data[AW];

  // Amt and mode are fully consumed by the last stage.
  assign w_unused = ^{w_amt[AW], w_mode[AW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed + exhaustive bench for pipelined_barrel_shifter (WIDTH = 8) with an expected-result queue.
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic         in_dir;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests;
  int           n_fail;
  int           n_edge;
  int           last_pop;
  logic [W-1:0] pend_exp;
  logic [W-1:0] hold_exp;
  bit           accepted;
  bit           lat_chk;
  bit           consec_chk;
  bit           have_last;

  function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int a,
                                             input logic dr, input logic [1:0] m);
    logic [2*W-1:0]    dd;
    logic signed [W-1:0] s;
    dd = {d, d};
    s  = d;
    case (m)
      2'd1: return dr ? W'(d << a) : W'(d >> a);
      2'd2: return dr ? W'(d << a) : W'(s >>> a);
      default: begin
        if (dr) begin
          dd = dd << a;
          return dd[2*W-1:W];
        end
        dd = dd >> a;
        return dd[W-1:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (in_valid && in_ready) begin
      exp_q.push_back('{data: pend_exp, acc: n_edge + 1});
      accepted = 1'b1;
    end
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data", 32'(out_data), 32'(e.data));
        if (lat_chk) chk("latency", 32'(n_edge + 1 - e.acc), 32'(AW));
        if (consec_chk && have_last) chk("consecutive", 32'(n_edge + 1 - last_pop), 32'd1);
        have_last = 1'b1;
        last_pop  = n_edge + 1;
      end
    end
    @(posedge clk);
    n_edge++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dr,
                      input logic [1:0] m, input logic [W-1:0] exp);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dr;
    in_mode  = m;
    pend_exp = exp;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) tick();
    if (!accepted) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_edge = 0; last_pop = 0;
    lat_chk = 1'b1; consec_chk = 1'b0; have_last = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_dir = 1'b0; in_mode = 2'd0; out_ready = 1'b1; pend_exp = '0;

    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    idle(2);

    send(8'hB1, 3'd3, DIR_RIGHT, MODE_ROT, 8'h36);
    drain();
    send(8'hB1, 3'd3, DIR_RIGHT, MODE_LSH, 8'h16);
    drain();
    send(8'hB1, 3'd3, DIR_RIGHT, MODE_ASH, 8'hF6);
    drain();
    send(8'hB1, 3'd3, DIR_LEFT, MODE_ROT, 8'h8D);
    drain();
    send(8'hB1, 3'd3, DIR_LEFT, MODE_LSH, 8'h88);
    drain();
    send(8'hB1, 3'd3, DIR_LEFT, MODE_ASH, 8'h88);
    send(8'hB1, 3'd3, DIR_RIGHT, MODE_RSV, 8'h36);
    send(8'hB1, 3'd3, DIR_LEFT, MODE_RSV, 8'h8D);
    send(8'h80, 3'd7, DIR_RIGHT, MODE_ASH, 8'hFF);
    send(8'h7F, 3'd7, DIR_RIGHT, MODE_ASH, 8'h00);
    send(8'h01, 3'd7, DIR_LEFT, MODE_LSH, 8'h80);
    for (int m = 0; m < 4; m++)
      for (int dr = 0; dr < 2; dr++)
        send(8'hB1, 3'd0, 1'(dr), 2'(m), 8'hB1);
    drain();

    // Eight operations on consecutive cycles must leave on consecutive cycles.
    consec_chk = 1'b1;
    have_last  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic          dr;
      logic [1:0]    m;
      d  = W'($urandom_range(0, 255));
      a  = AW'($urandom_range(0, 7));
      dr = 1'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      send(d, a, dr, m, ref_model(d, int'(a), dr, m));
    end
    drain();
    consec_chk = 1'b0;

    // Fill the pipe with the consumer stalled, hold 4 cycles, then release.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send(8'hC3, 3'd1, DIR_RIGHT, MODE_ROT, 8'hE1);
    send(8'hC3, 3'd2, DIR_LEFT, MODE_LSH, 8'h0C);
    send(8'hC3, 3'd5, DIR_RIGHT, MODE_ASH, 8'hFE);
    chk("stall_full_valid", 32'(out_valid), 32'd1);
    hold_exp = 8'hE1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_amt   = 3'd4;
    in_dir   = DIR_LEFT;
    in_mode  = MODE_ROT;
    pend_exp = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", 32'(out_data), 32'(hold_exp));
    end
    chk("stall_queue", 32'(exp_q.size()), 32'd3);
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) tick();
    chk("stall_late_accept", 32'(accepted), 32'd1);
    drain();
    lat_chk = 1'b1;

    // Reset with two operations in flight, the older already at the output.
    send(8'h96, 3'd2, DIR_RIGHT, MODE_LSH, 8'h25);
    send(8'h96, 3'd2, DIR_LEFT, MODE_ROT, 8'h5A);
    idle(1);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    chk("inflight_count", 32'(exp_q.size()), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_data", 32'(out_data), 32'd0);
    exp_q.delete();
    #2;
    reset_n = 1'b1;
    chk("ready_after_reset2", 32'(in_ready), 32'd1);
    idle(6);
    chk("no_stale_result", 32'(out_valid), 32'd0);

    // Exhaustive sweep, issued back to back.
    for (int d = 0; d < 256; d++)
      for (int a = 0; a < 8; a++)
        for (int dr = 0; dr < 2; dr++)
          for (int m = 0; m < 4; m++)
            send(W'(d), AW'(a), 1'(dr), 2'(m), ref_model(W'(d), a, 1'(dr), 2'(m)));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
